glitc_debug_mux_n: RTL and testbench



---
 rtl/glitc_debug_mux_n_if.sv | 29 ++
 rtl/glitc_debug_mux_n.sv | 143 ++++++++++++++
 tb/tb_glitc_debug_mux_n.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/glitc_debug_mux_n_if.sv
// Debug selector bundle: channel buses, select write, freeze, selected word and status.
// Inputs are sampled on the debug clock; the outputs are registered and have no backpressure.
interface glitc_debug_mux_n_if #(
   parameter int WIDTH = 71,
   parameter int NCH   = 8,
   parameter int SELW  = 3,
   parameter int CNTW  = 16
);
   logic [SELW-1:0]      sel_i;
   logic                 sel_wr_i;
   logic [NCH*WIDTH-1:0] debug_i;
   logic                 freeze_i;
   logic [WIDTH-1:0]     debug_o;
   logic                 valid_o;
   logic [SELW-1:0]      sel_o;
   logic                 busy_o;
   logic                 sel_err_o;
   logic [CNTW-1:0]      count_o;

   modport master (
      output sel_i, sel_wr_i, debug_i, freeze_i,
      input  debug_o, valid_o, sel_o, busy_o, sel_err_o, count_o
   );

   modport slave (
      input  sel_i, sel_wr_i, debug_i, freeze_i,
      output debug_o, valid_o, sel_o, busy_o, sel_err_o, count_o
   );
endinterface

// File: rtl/glitc_debug_mux_n.sv
// Registered NCH:1 debug-bus selector with post-switch blanking, freeze and a per-selection word count.
// 1-cycle input-to-output latency once running; no backpressure, freeze_i only holds the output.
module glitc_debug_mux_n #(
   parameter int WIDTH = 71,
   parameter int NCH   = 8,
   parameter int SELW  = 3,
   parameter int BLANK = 4,
   parameter int CNTW  = 16
) (
   input logic                clk_i,
   input logic                rst_i,
   glitc_debug_mux_n_if.slave dbg
);
   localparam int NSLOT = 1 << SELW;
   localparam int BW    = (BLANK > 0) ? $clog2(BLANK + 1) : 1;

   localparam logic [BW-1:0]   BLANK_INIT   = BW'(BLANK);
   localparam logic [BW-1:0]   BLANK_RELOAD = (BLANK > 0) ? BW'(BLANK - 1) : '0;
   localparam logic [SELW:0]   NCH_LIM      = NCH[SELW:0];
   localparam logic [CNTW-1:0] CNT_ONE      = CNTW'(1);

   if (NCH < 2 || NCH > 16 || NSLOT < NCH || BLANK < 0 || CNTW < 1) begin : g_param_check
      $error("glitc_debug_mux_n: invalid parameter set");
   end

   typedef enum logic [1:0] {
      ST_RUN,
      ST_SWITCH,
      ST_FROZEN
   } state_t;

   // Unpopulated select codes read as zero so the array index is always in range.
   logic [WIDTH-1:0] chan [NSLOT];

   for (genvar c = 0; c < NSLOT; c++) begin : g_chan
      if (c < NCH) begin : g_live
         assign chan[c] = dbg.debug_i[c*WIDTH +: WIDTH];
      end else begin : g_pad
         assign chan[c] = '0;
      end
   end

   state_t          state;
   logic [BW-1:0]   blank_cnt;
   logic [WIDTH-1:0] debug_q;
   logic            valid_q;
   logic [SELW-1:0] sel_q;
   logic            busy_q;
   logic            err_q;
   logic [CNTW-1:0] cnt_q;

   logic             sel_ok;
   logic             wr_ok;
   logic [WIDTH-1:0] req_word;
   logic [WIDTH-1:0] cur_word;

   assign sel_ok   = ({1'b0, dbg.sel_i} < NCH_LIM);
   assign wr_ok    = dbg.sel_wr_i && sel_ok;
   assign req_word = chan[dbg.sel_i];
   assign cur_word = chan[sel_q];

   // Reset parks in SWITCH with a full count, so release behaves like a write of channel 0.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state     <= ST_SWITCH;
         blank_cnt <= BLANK_INIT;
         debug_q   <= '0;
         valid_q   <= 1'b0;
         sel_q     <= '0;
         busy_q    <= (BLANK > 0);
         err_q     <= 1'b0;
         cnt_q     <= '0;
      end else begin
         if (dbg.sel_wr_i && !sel_ok) begin
            err_q <= 1'b1;
         end

         if (wr_ok) begin
            sel_q <= dbg.sel_i;
            err_q <= 1'b0;
            if (BLANK == 0) begin
               debug_q <= req_word;
               valid_q <= 1'b1;
               busy_q  <= 1'b0;
               cnt_q   <= CNT_ONE;
               state   <= ST_RUN;
            end else begin
               debug_q   <= '0;
               valid_q   <= 1'b0;
               busy_q    <= 1'b1;
               cnt_q     <= '0;
               blank_cnt <= BLANK_RELOAD;
               state     <= ST_SWITCH;
            end
         end else begin
            case (state)
               // First word after blanking always loads, whatever freeze_i says.
               ST_SWITCH: begin
                  if (blank_cnt == '0) begin
                     debug_q <= cur_word;
                     valid_q <= 1'b1;
                     busy_q  <= 1'b0;
                     cnt_q   <= CNT_ONE;
                     state   <= ST_RUN;
                  end else begin
                     blank_cnt <= blank_cnt - BW'(1);
                  end
               end
               ST_RUN: begin
                  if (dbg.freeze_i) begin
                     state <= ST_FROZEN;
                  end else begin
                     debug_q <= cur_word;
                     cnt_q   <= cnt_q + CNT_ONE;
                  end
               end
               ST_FROZEN: begin
                  if (!dbg.freeze_i) begin
                     debug_q <= cur_word;
                     cnt_q   <= cnt_q + CNT_ONE;
                     state   <= ST_RUN;
                  end
               end
               default: begin
                  state     <= ST_SWITCH;
                  blank_cnt <= BLANK_INIT;
                  debug_q   <= '0;
                  valid_q   <= 1'b0;
                  busy_q    <= (BLANK > 0);
                  cnt_q     <= '0;
               end
            endcase
         end
      end
   end

   assign dbg.debug_o   = debug_q;
   assign dbg.valid_o   = valid_q;
   assign dbg.sel_o     = sel_q;
   assign dbg.busy_o    = busy_q;
   assign dbg.sel_err_o = err_q;
   assign dbg.count_o   = cnt_q;
endmodule

// File: tb/tb_glitc_debug_mux_n.sv
// Bench for glitc_debug_mux_n: a BLANK=4 and a BLANK=0 instance driven with the same stimulus.
// Directed vector table, hand sequences for freeze/reset corners, then random traffic against a timeline model.
module tb_glitc_debug_mux_n;
   localparam int WIDTH   = 71;
   localparam int NCH     = 8;
   localparam int SELW    = 4;
   localparam int CW_A    = 16;
   localparam int CW_B    = 4;
   localparam int BLANK_A = 4;
   localparam int NVEC    = 29;

   logic clk_i = 1'b0;
   logic rst_i;
   always #5 clk_i = ~clk_i;

   glitc_debug_mux_n_if #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW), .CNTW(CW_A)) a_if ();
   glitc_debug_mux_n_if #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW), .CNTW(CW_B)) b_if ();

   glitc_debug_mux_n #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW), .BLANK(BLANK_A), .CNTW(CW_A)) u_a (
      .clk_i(clk_i), .rst_i(rst_i), .dbg(a_if));
   glitc_debug_mux_n #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW), .BLANK(0), .CNTW(CW_B)) u_b (
      .clk_i(clk_i), .rst_i(rst_i), .dbg(b_if));

   // Timeline model: n = edges since reset release, wr_edge = edge of last accepted write
   // (release counts as a write at edge 1). Blank while n < wr_edge+blank, first word at equality.
   typedef struct {
      int               n;
      int               wr_edge;
      logic [SELW-1:0]  sel;
      logic [WIDTH-1:0] word;
      int               cnt;
      logic             err;
   } mdl_t;

   typedef struct {
      logic wr;
      int   sel;
      logic frz;
      logic v;
      logic b;
      int   s;
      logic e;
      int   c;
      int   ch;
      int   tk;
   } vec_t;

   int                   checks;
   int                   errors;
   int                   tick;
   bit                   rnd_mode;
   logic [NCH*WIDTH-1:0] din;
   mdl_t                 ma, mb;
   vec_t                 tbl [NVEC];

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [WIDTH-1:0] stamp(input int ch, input int tk);
      logic [WIDTH-1:0] w;
      w        = '0;
      w[39:32] = ch[7:0];
      w[31:0]  = tk;
      return w;
   endfunction

   function automatic logic [WIDTH-1:0] rand_word();
      logic [95:0] r;
      r = {$urandom, $urandom, $urandom};
      return r[WIDTH-1:0];
   endfunction

   function automatic mdl_t mdl_reset();
      mdl_t m;
      m.n = 0; m.wr_edge = 1; m.sel = '0; m.word = '0; m.cnt = 0; m.err = 1'b0;
      return m;
   endfunction

   function automatic mdl_t mdl_step(input mdl_t mi, input int blank, input logic wr,
                                     input logic [SELW-1:0] s, input logic frz,
                                     input logic [NCH*WIDTH-1:0] d);
      mdl_t m;
      m   = mi;
      m.n = m.n + 1;
      if (wr && int'(s) < NCH) begin
         m.wr_edge = m.n; m.sel = s; m.err = 1'b0; m.cnt = 0;
      end else if (wr) begin
         m.err = 1'b1;
      end
      if (m.n < m.wr_edge + blank) begin
         m.word = '0;
      end else if (m.n == m.wr_edge + blank) begin
         m.word = d[int'(m.sel)*WIDTH +: WIDTH];
         m.cnt  = 1;
      end else if (!frz) begin
         m.word = d[int'(m.sel)*WIDTH +: WIDTH];
         m.cnt  = m.cnt + 1;
      end
      return m;
   endfunction

   task automatic cmp_one(input string p, input mdl_t m, input int blank, input int cw,
                          input logic [WIDTH-1:0] d, input logic v, input logic [SELW-1:0] s,
                          input logic b, input logic e, input int c);
      logic live;
      live = (m.n >= m.wr_edge + blank);
      chk({p, ".debug_o"},   128'(d), 128'(m.word));
      chk({p, ".valid_o"},   128'(v), 128'(live));
      chk({p, ".sel_o"},     128'(s), 128'(m.sel));
      chk({p, ".busy_o"},    128'(b), 128'((blank > 0) && !live));
      chk({p, ".sel_err_o"}, 128'(e), 128'(m.err));
      chk({p, ".count_o"},   128'(c), 128'(m.cnt % (1 << cw)));
   endtask

   task automatic cmp_model();
      cmp_one("a", ma, BLANK_A, CW_A, a_if.debug_o, a_if.valid_o, a_if.sel_o, a_if.busy_o,
              a_if.sel_err_o, int'(a_if.count_o));
      cmp_one("b", mb, 0, CW_B, b_if.debug_o, b_if.valid_o, b_if.sel_o, b_if.busy_o,
              b_if.sel_err_o, int'(b_if.count_o));
   endtask

   task automatic drive(input logic wr, input logic [SELW-1:0] s, input logic frz);
      a_if.sel_wr_i = wr; a_if.sel_i = s; a_if.freeze_i = frz; a_if.debug_i = din;
      b_if.sel_wr_i = wr; b_if.sel_i = s; b_if.freeze_i = frz; b_if.debug_i = din;
   endtask

   // One clock: drive, take the edge, advance both models, compare 1ns after the edge.
   task automatic step(input logic wr, input logic [SELW-1:0] s, input logic frz);
      tick++;
      for (int c = 0; c < NCH; c++) begin
         din[c*WIDTH +: WIDTH] = rnd_mode ? rand_word() : stamp(c, tick);
      end
      drive(wr, s, frz);
      @(posedge clk_i);
      ma = mdl_step(ma, BLANK_A, wr, s, frz, din);
      mb = mdl_step(mb, 0, wr, s, frz, din);
      #1;
      cmp_model();
   endtask

   // Asynchronous reset raised between edges; outputs must clear before any clock edge.
   task automatic do_reset();
      #3;
      rst_i = 1'b1;
      #1;
      chk("rst_async.a.debug_o", 128'(a_if.debug_o), 128'(0));
      chk("rst_async.a.valid_o", 128'(a_if.valid_o), 128'(0));
      chk("rst_async.a.busy_o",  128'(a_if.busy_o),  128'(1));
      chk("rst_async.a.count_o", 128'(a_if.count_o), 128'(0));
      chk("rst_async.a.sel_o",   128'(a_if.sel_o),   128'(0));
      chk("rst_async.b.debug_o", 128'(b_if.debug_o), 128'(0));
      chk("rst_async.b.valid_o", 128'(b_if.valid_o), 128'(0));
      chk("rst_async.b.busy_o",  128'(b_if.busy_o),  128'(0));
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      ma = mdl_reset();
      mb = mdl_reset();
      cmp_model();
   endtask

   function automatic vec_t row(input logic wr, input int sel, input logic frz, input logic v,
                                input logic b, input int s, input logic e, input int c,
                                input int ch, input int tk);
      vec_t r;
      r.wr = wr; r.sel = sel; r.frz = frz; r.v = v; r.b = b;
      r.s = s; r.e = e; r.c = c; r.ch = ch; r.tk = tk;
      return r;
   endfunction

   initial begin
      logic            wr;
      logic            frz;
      logic [SELW-1:0] s;
      int              th;

      checks = 0; errors = 0; tick = 0; rnd_mode = 1'b0;

      // Row k is edge k+1 after release, for the BLANK=4 instance; ch=-1 means blanked output.
      //            wr    sel frz   v     b     s  e     c   ch  tk
      tbl[0]  = row(1'b0, 0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 0, -1, 0);
      tbl[1]  = row(1'b0, 0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 0, -1, 0);
      tbl[2]  = row(1'b0, 0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 0, -1, 0);
      tbl[3]  = row(1'b0, 0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 0, -1, 0);
      tbl[4]  = row(1'b0, 0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1,  0, 5);
      tbl[5]  = row(1'b0, 0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 2,  0, 6);
      tbl[6]  = row(1'b1, 5, 1'b0, 1'b0, 1'b1, 5, 1'b0, 0, -1, 0);
      tbl[7]  = row(1'b0, 0, 1'b0, 1'b0, 1'b1, 5, 1'b0, 0, -1, 0);
      tbl[8]  = row(1'b0, 0, 1'b0, 1'b0, 1'b1, 5, 1'b0, 0, -1, 0);
      tbl[9]  = row(1'b0, 0, 1'b0, 1'b0, 1'b1, 5, 1'b0, 0, -1, 0);
      tbl[10] = row(1'b0, 0, 1'b0, 1'b1, 1'b0, 5, 1'b0, 1,  5, 11);
      tbl[11] = row(1'b0, 0, 1'b0, 1'b1, 1'b0, 5, 1'b0, 2,  5, 12);
      tbl[12] = row(1'b0, 0, 1'b1, 1'b1, 1'b0, 5, 1'b0, 2,  5, 12);
      tbl[13] = row(1'b1, 9, 1'b1, 1'b1, 1'b0, 5, 1'b1, 2,  5, 12);
      tbl[14] = row(1'b0, 0, 1'b0, 1'b1, 1'b0, 5, 1'b1, 3,  5, 15);
      tbl[15] = row(1'b1, 2, 1'b0, 1'b0, 1'b1, 2, 1'b0, 0, -1, 0);
      tbl[16] = row(1'b0, 0, 1'b0, 1'b0, 1'b1, 2, 1'b0, 0, -1, 0);
      tbl[17] = row(1'b1, 3, 1'b0, 1'b0, 1'b1, 3, 1'b0, 0, -1, 0);
      tbl[18] = row(1'b0, 0, 1'b0, 1'b0, 1'b1, 3, 1'b0, 0, -1, 0);
      tbl[19] = row(1'b0, 0, 1'b1, 1'b0, 1'b1, 3, 1'b0, 0, -1, 0);
      tbl[20] = row(1'b0, 0, 1'b1, 1'b0, 1'b1, 3, 1'b0, 0, -1, 0);
      tbl[21] = row(1'b0, 0, 1'b1, 1'b1, 1'b0, 3, 1'b0, 1,  3, 22);
      tbl[22] = row(1'b0, 0, 1'b1, 1'b1, 1'b0, 3, 1'b0, 1,  3, 22);
      tbl[23] = row(1'b1, 1, 1'b1, 1'b0, 1'b1, 1, 1'b0, 0, -1, 0);
      tbl[24] = row(1'b0, 0, 1'b0, 1'b0, 1'b1, 1, 1'b0, 0, -1, 0);
      tbl[25] = row(1'b0, 0, 1'b0, 1'b0, 1'b1, 1, 1'b0, 0, -1, 0);
      tbl[26] = row(1'b0, 0, 1'b0, 1'b0, 1'b1, 1, 1'b0, 0, -1, 0);
      tbl[27] = row(1'b0, 0, 1'b0, 1'b1, 1'b0, 1, 1'b0, 1,  1, 28);
      tbl[28] = row(1'b0, 0, 1'b0, 1'b1, 1'b0, 1, 1'b0, 2,  1, 29);

      rst_i = 1'b1;
      din   = '0;
      drive(1'b0, '0, 1'b0);
      ma = mdl_reset();
      mb = mdl_reset();
      repeat (2) @(posedge clk_i);
      #1;
      cmp_model();
      chk("reset.a.busy_o", 128'(a_if.busy_o), 128'(1));
      chk("reset.b.busy_o", 128'(b_if.busy_o), 128'(0));
      rst_i = 1'b0;

      for (int i = 0; i < NVEC; i++) begin
         step(tbl[i].wr, SELW'(tbl[i].sel), tbl[i].frz);
         chk($sformatf("vec%0d.debug_o", i), 128'(a_if.debug_o),
             (tbl[i].ch < 0) ? 128'(0) : 128'(stamp(tbl[i].ch, tbl[i].tk)));
         chk($sformatf("vec%0d.valid_o", i),   128'(a_if.valid_o),   128'(tbl[i].v));
         chk($sformatf("vec%0d.busy_o", i),    128'(a_if.busy_o),    128'(tbl[i].b));
         chk($sformatf("vec%0d.sel_o", i),     128'(a_if.sel_o),     128'(tbl[i].s));
         chk($sformatf("vec%0d.sel_err_o", i), 128'(a_if.sel_err_o), 128'(tbl[i].e));
         chk($sformatf("vec%0d.count_o", i),   128'(a_if.count_o),   128'(tbl[i].c));
      end

      // Run channel 1 up to count 20, hold freeze for 10 cycles, release.
      for (int i = 0; i < 18; i++) step(1'b0, SELW'(1), 1'b0);
      chk("freeze.pre_count", 128'(a_if.count_o), 128'(20));
      th = tick;
      for (int i = 0; i < 10; i++) begin
         step(1'b0, SELW'(1), 1'b1);
         chk("freeze.count_o", 128'(a_if.count_o), 128'(20));
         chk("freeze.debug_o", 128'(a_if.debug_o), 128'(stamp(1, th)));
         chk("freeze.valid_o", 128'(a_if.valid_o), 128'(1));
      end
      step(1'b0, SELW'(1), 1'b0);
      chk("release.count_o", 128'(a_if.count_o), 128'(21));
      chk("release.debug_o", 128'(a_if.debug_o), 128'(stamp(1, tick)));

      // BLANK=0 instance: new channel appears at the accepting edge, valid never drops.
      chk("b0.pre_valid", 128'(b_if.valid_o), 128'(1));
      step(1'b1, SELW'(6), 1'b0);
      chk("b0.wr.debug_o", 128'(b_if.debug_o), 128'(stamp(6, tick)));
      chk("b0.wr.valid_o", 128'(b_if.valid_o), 128'(1));
      chk("b0.wr.count_o", 128'(b_if.count_o), 128'(1));
      step(1'b1, SELW'(4), 1'b1);
      th = tick;
      chk("b0.wrfrz.debug_o", 128'(b_if.debug_o), 128'(stamp(4, th)));
      step(1'b0, SELW'(4), 1'b1);
      chk("b0.frz.debug_o", 128'(b_if.debug_o), 128'(stamp(4, th)));
      chk("b0.frz.count_o", 128'(b_if.count_o), 128'(1));
      chk("b0.frz.valid_o", 128'(b_if.valid_o), 128'(1));

      // Reset while frozen, then the BLANK=4 instance must blank again for 4 edges.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         step(1'b0, '0, 1'b0);
         chk("rst_restart.valid_o", 128'(a_if.valid_o), 128'(0));
      end
      step(1'b0, '0, 1'b0);
      chk("rst_restart.load_valid", 128'(a_if.valid_o), 128'(1));
      chk("rst_restart.load_count", 128'(a_if.count_o), 128'(1));
      chk("rst_restart.load_debug", 128'(a_if.debug_o), 128'(stamp(0, tick)));

      rnd_mode = 1'b1;
      frz      = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 299) == 0) do_reset();
         wr = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 5) == 0) frz = ~frz;
         s = SELW'($urandom_range(0, NCH - 1));
         // Out-of-range writes only while output is held, where holding is the only outcome.
         if (wr && frz && (ma.n + 1 > ma.wr_edge + BLANK_A) && $urandom_range(0, 2) == 0)
            s = SELW'($urandom_range(NCH, (1 << SELW) - 1));
         step(wr, s, frz);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
